// File: rtl/hpdcache_cmo_issuer_pkg.sv
// hpdcache_cmo_issuer_pkg: CMO code/op types, request field types and code-to-op mapping
package hpdcache_cmo_issuer_pkg;
    localparam int unsigned HPDCACHE_WAYS = 4;
    localparam int unsigned HPDCACHE_PA_WIDTH = 32;
    localparam int unsigned HPDCACHE_REQ_DATA_WIDTH = 64;
    typedef logic [HPDCACHE_PA_WIDTH-1:0] hpdcache_req_addr_t;
    typedef logic [HPDCACHE_REQ_DATA_WIDTH-1:0] hpdcache_req_data_t;
    typedef logic [HPDCACHE_WAYS-1:0] hpdcache_way_vector_t;
    typedef enum logic [2:0] {
        CMO_FENCE       = 3'd0,
        CMO_INVAL_NLINE = 3'd1,
        CMO_INVAL_SET   = 3'd2,
        CMO_INVAL_ALL   = 3'd3
    } hpdcache_cmo_code_e;
    typedef struct packed {
        logic is_inval_all;
        logic is_inval_by_set;
        logic is_inval_by_nline;
        logic is_fence;
    } hpdcache_cmoh_op_t;
    typedef enum logic [1:0] {
        CMO_IDLE,
        CMO_ISSUE,
        CMO_WAIT_DONE
    } hpdcache_cmo_issuer_state_e;
    // Illegal codes map to an all-zero op
    function automatic hpdcache_cmoh_op_t hpdcache_cmo_code_to_op(input logic [2:0] code);
        hpdcache_cmoh_op_t op;
        op.is_fence = code == CMO_FENCE;
        op.is_inval_by_nline = code == CMO_INVAL_NLINE;
        op.is_inval_by_set = code == CMO_INVAL_SET;
        op.is_inval_all = code == CMO_INVAL_ALL;
        return op;
    endfunction
endpackage

// File: rtl/hpdcache_cmo_cmd_fifo.sv
// hpdcache_cmo_cmd_fifo: register FIFO holding queued CMO commands
module hpdcache_cmo_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0] cnt_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + AW'(push_i);
            rd_ptr_q <= rd_ptr_q + AW'(pop_i);
            cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
        end
    end
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end
    assign data_o = mem_q[rd_ptr_q];
    assign full_o = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
endmodule

// File: rtl/hpdcache_cmo_issuer.sv
// hpdcache_cmo_issuer: queues core CMO commands, issues them one at a time to the
// CMO handler and reports per-command completion with its tag
module hpdcache_cmo_issuer
    import hpdcache_cmo_issuer_pkg::*;
#(
    parameter int unsigned CMD_FIFO_DEPTH = 4,
    parameter int unsigned TAG_WIDTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cmo_valid_i,
    output logic                 cmo_ready_o,
    input  logic [2:0]           cmo_op_i,
    input  hpdcache_req_addr_t   cmo_addr_i,
    input  hpdcache_way_vector_t cmo_way_i,
    input  logic [TAG_WIDTH-1:0] cmo_tag_i,
    output logic                 cmo_rsp_valid_o,
    output logic [TAG_WIDTH-1:0] cmo_rsp_tag_o,
    output logic                 cmo_rsp_error_o,
    output logic                 req_valid_o,
    input  logic                 req_ready_i,
    output hpdcache_cmoh_op_t    req_op_o,
    output hpdcache_req_addr_t   req_addr_o,
    output hpdcache_req_data_t   req_wdata_o,
    output logic                 busy_o
);
    localparam int unsigned ENTRY_WIDTH = 3 + HPDCACHE_PA_WIDTH + HPDCACHE_WAYS + TAG_WIDTH;

    hpdcache_cmo_issuer_state_e state_q, state_d;
    logic fifo_full, fifo_empty, push, pop, latch, done, rsp_d;
    logic head_illegal, head_noop;
    logic [ENTRY_WIDTH-1:0] head;
    logic [2:0] head_op;
    hpdcache_req_addr_t head_addr, cmd_addr_q;
    hpdcache_way_vector_t head_way, cmd_way_q;
    logic [TAG_WIDTH-1:0] head_tag, cmd_tag_q, rsp_tag_q;
    hpdcache_cmoh_op_t cmd_op_q;
    logic rsp_valid_q, rsp_error_q;

    assign cmo_ready_o = !fifo_full;
    assign push = cmo_valid_i && cmo_ready_o;
    assign {head_op, head_addr, head_way, head_tag} = head;
    assign head_illegal = head_op[2];
    // An inval-by-set with no way selected has nothing to do and completes locally
    assign head_noop = head_op == CMO_INVAL_SET && head_way == '0;

    hpdcache_cmo_cmd_fifo #(
        .DEPTH(CMD_FIFO_DEPTH),
        .WIDTH(ENTRY_WIDTH)
    ) i_cmd_fifo (
        .clk_i,
        .rst_ni,
        .push_i (push),
        .data_i ({cmo_op_i, cmo_addr_i, cmo_way_i, cmo_tag_i}),
        .pop_i  (pop),
        .data_o (head),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= CMO_IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            CMO_IDLE:      state_d = latch ? CMO_ISSUE : CMO_IDLE;
            CMO_ISSUE:     state_d = req_ready_i ? CMO_WAIT_DONE : CMO_ISSUE;
            CMO_WAIT_DONE: state_d = req_ready_i ? CMO_IDLE : CMO_WAIT_DONE;
            default:       state_d = CMO_IDLE;
        endcase
    end

    always_comb begin
        pop = state_q == CMO_IDLE && !fifo_empty;
        latch = pop && !head_illegal && !head_noop;
        done = state_q == CMO_WAIT_DONE && req_ready_i;
        rsp_d = (pop && !latch) || done;
        req_valid_o = state_q == CMO_ISSUE;
        req_op_o = req_valid_o ? cmd_op_q : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmd_op_q <= '0;
            cmd_addr_q <= '0;
            cmd_way_q <= '0;
            cmd_tag_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_tag_q <= '0;
        end else begin
            if (latch) begin
                cmd_op_q <= hpdcache_cmo_code_to_op(head_op);
                cmd_addr_q <= head_addr;
                cmd_way_q <= head_way;
                cmd_tag_q <= head_tag;
            end
            rsp_valid_q <= rsp_d;
            if (rsp_d) begin
                rsp_error_q <= pop && head_illegal;
                rsp_tag_q <= done ? cmd_tag_q : head_tag;
            end
        end
    end

    assign cmo_rsp_valid_o = rsp_valid_q;
    assign cmo_rsp_error_o = rsp_error_q;
    assign cmo_rsp_tag_o = rsp_tag_q;
    assign req_addr_o = cmd_addr_q;
    assign req_wdata_o = hpdcache_req_data_t'(cmd_way_q);
    assign busy_o = !fifo_empty || state_q != CMO_IDLE;
endmodule

// File: tb/tb_hpdcache_cmo_issuer.sv
// tb_hpdcache_cmo_issuer: directed and randomized checks of the CMO issuer against
// an in-order command/response queue model
module tb_hpdcache_cmo_issuer;
    import hpdcache_cmo_issuer_pkg::*;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic cmo_valid_i, cmo_ready_o, cmo_rsp_valid_o, cmo_rsp_error_o;
    logic [2:0] cmo_op_i;
    logic [31:0] cmo_addr_i, req_addr_o;
    logic [3:0] cmo_way_i, cmo_tag_i, cmo_rsp_tag_o;
    logic req_valid_o, req_ready_i, busy_o;
    hpdcache_cmoh_op_t req_op_o;
    logic [63:0] req_wdata_o;

    typedef struct {logic [3:0] op; logic [31:0] addr; logic [63:0] wdata;} req_t;
    typedef struct {logic [3:0] tag; logic err;} rsp_t;
    req_t exp_req[$];
    rsp_t exp_rsp[$];
    req_t mon_req;
    rsp_t mon_rsp;
    int checks = 0;
    int errors = 0;
    logic rand_ready = 1'b0;

    always #5 clk = ~clk;

    hpdcache_cmo_issuer dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .cmo_valid_i(cmo_valid_i), .cmo_ready_o(cmo_ready_o), .cmo_op_i(cmo_op_i),
        .cmo_addr_i(cmo_addr_i), .cmo_way_i(cmo_way_i), .cmo_tag_i(cmo_tag_i),
        .cmo_rsp_valid_o(cmo_rsp_valid_o), .cmo_rsp_tag_o(cmo_rsp_tag_o), .cmo_rsp_error_o(cmo_rsp_error_o),
        .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_op_o(req_op_o),
        .req_addr_o(req_addr_o), .req_wdata_o(req_wdata_o), .busy_o(busy_o)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, got, exp);
        end
    endtask

    // Every command answers in order; only legal, non-empty commands reach the handler
    task automatic push(input logic [2:0] op, input logic [31:0] addr, input logic [3:0] way, input logic [3:0] tag);
        int n = 0;
        rsp_t r;
        req_t q;
        cmo_valid_i = 1'b1;
        cmo_op_i = op;
        cmo_addr_i = addr;
        cmo_way_i = way;
        cmo_tag_i = tag;
        @(negedge clk);
        while (!cmo_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("push_ready", 64'(n < 200), 1);
        @(posedge clk);
        if (n < 200) begin
            r.tag = tag;
            r.err = op >= 3'd4;
            exp_rsp.push_back(r);
            if (op < 3'd4 && !(op == 3'd2 && way == 4'd0)) begin
                q.op = 4'b0001 << op;
                q.addr = addr;
                q.wdata = {60'd0, way};
                exp_req.push_back(q);
            end
        end
        #1 cmo_valid_i = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_rsp.size() != 0 || busy_o) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(n < 2000), 1);
    endtask

    always @(negedge clk) begin
        if (rst_ni) begin
            if (req_valid_o) check("req_onehot", 64'($onehot(req_op_o)), 1);
            else check("req_op_idle", 64'(req_op_o), 0);
            if (req_valid_o && req_ready_i) begin
                check("req_expected", 64'(exp_req.size() != 0), 1);
                if (exp_req.size() != 0) begin
                    mon_req = exp_req.pop_front();
                    check("req_op", 64'(req_op_o), 64'(mon_req.op));
                    check("req_addr", 64'(req_addr_o), 64'(mon_req.addr));
                    check("req_wdata", req_wdata_o, mon_req.wdata);
                end
            end
            if (cmo_rsp_valid_o) begin
                check("rsp_expected", 64'(exp_rsp.size() != 0), 1);
                if (exp_rsp.size() != 0) begin
                    mon_rsp = exp_rsp.pop_front();
                    check("rsp_tag", 64'(cmo_rsp_tag_o), 64'(mon_rsp.tag));
                    check("rsp_error", 64'(cmo_rsp_error_o), 64'(mon_rsp.err));
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_ready) req_ready_i = 1'($urandom_range(0, 1));
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        cmo_valid_i = 1'b0;
        cmo_op_i = '0;
        cmo_addr_i = '0;
        cmo_way_i = '0;
        cmo_tag_i = '0;
        req_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_valid", 64'(req_valid_o), 0);
        check("rst_rsp_valid", 64'(cmo_rsp_valid_o), 0);
        check("rst_busy", 64'(busy_o), 0);
        check("rst_req_op", 64'(req_op_o), 0);
        check("rst_rsp_tag", 64'(cmo_rsp_tag_o), 0);
        @(posedge clk);
        #1 rst_ni = 1'b1;
        req_ready_i = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 64'(cmo_ready_o), 1);
        check("post_rst_busy", 64'(busy_o), 0);
        // fence with an always-ready handler
        @(posedge clk);
        #1 push(3'd0, 32'h0, 4'h0, 4'd3);
        @(negedge clk);
        check("t1_not_yet", 64'(req_valid_o), 0);
        @(negedge clk);
        check("t1_valid", 64'(req_valid_o), 1);
        check("t1_op", 64'(req_op_o), 64'h1);
        @(negedge clk);
        check("t1_single", 64'(req_valid_o), 0);
        check("t1_no_rsp_yet", 64'(cmo_rsp_valid_o), 0);
        @(negedge clk);
        check("t1_rsp", 64'(cmo_rsp_valid_o), 1);
        check("t1_tag", 64'(cmo_rsp_tag_o), 3);
        check("t1_err", 64'(cmo_rsp_error_o), 0);
        // inval by set, handler stalls before and after acceptance
        @(posedge clk);
        #1 req_ready_i = 1'b0;
        push(3'd2, 32'h1040, 4'b0101, 4'd5);
        @(negedge clk);
        check("t2_not_yet", 64'(req_valid_o), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t2_held", 64'(req_valid_o), 1);
            check("t2_wdata", req_wdata_o, 64'h5);
            check("t2_addr", 64'(req_addr_o), 64'h1040);
            check("t2_op", 64'(req_op_o), 64'h4);
        end
        @(posedge clk);
        #1 req_ready_i = 1'b1;
        @(negedge clk);
        check("t2_accept", 64'(req_valid_o), 1);
        @(posedge clk);
        #1 req_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t2_wait_valid", 64'(req_valid_o), 0);
            check("t2_wait_rsp", 64'(cmo_rsp_valid_o), 0);
        end
        @(posedge clk);
        #1 req_ready_i = 1'b1;
        @(negedge clk);
        check("t2_rsp_early", 64'(cmo_rsp_valid_o), 0);
        @(negedge clk);
        check("t2_rsp", 64'(cmo_rsp_valid_o), 1);
        check("t2_tag", 64'(cmo_rsp_tag_o), 5);
        // inval by set with empty way mask completes without issuing
        @(posedge clk);
        #1 push(3'd2, 32'h2000, 4'h0, 4'd7);
        @(negedge clk);
        check("t3_no_rsp_yet", 64'(cmo_rsp_valid_o), 0);
        check("t3_no_req", 64'(req_valid_o), 0);
        @(negedge clk);
        check("t3_rsp", 64'(cmo_rsp_valid_o), 1);
        check("t3_tag", 64'(cmo_rsp_tag_o), 7);
        check("t3_err", 64'(cmo_rsp_error_o), 0);
        check("t3_no_req2", 64'(req_valid_o), 0);
        @(negedge clk);
        check("t3_idle", 64'(busy_o), 0);
        check("t3_no_req3", 64'(req_valid_o), 0);
        // illegal opcode followed by a fence
        @(posedge clk);
        #1 push(3'd6, 32'h0, 4'hf, 4'd9);
        push(3'd0, 32'h0, 4'h0, 4'd10);
        @(negedge clk);
        check("t4_rsp", 64'(cmo_rsp_valid_o), 1);
        check("t4_tag", 64'(cmo_rsp_tag_o), 9);
        check("t4_err", 64'(cmo_rsp_error_o), 1);
        check("t4_no_req", 64'(req_valid_o), 0);
        @(negedge clk);
        check("t4_fence_valid", 64'(req_valid_o), 1);
        check("t4_fence_op", 64'(req_op_o), 64'h1);
        @(negedge clk);
        check("t4_no_rsp", 64'(cmo_rsp_valid_o), 0);
        @(negedge clk);
        check("t4_fence_rsp", 64'(cmo_rsp_valid_o), 1);
        check("t4_fence_tag", 64'(cmo_rsp_tag_o), 10);
        check("t4_fence_err", 64'(cmo_rsp_error_o), 0);
        // fill the queue behind a stalled fence
        @(posedge clk);
        #1 req_ready_i = 1'b0;
        push(3'd0, 32'h0, 4'h0, 4'd15);
        for (int t = 0; t < 4; t++) push(3'd3, $urandom, 4'h0, 4'(t));
        @(negedge clk);
        check("t5_full", 64'(cmo_ready_o), 0);
        check("t5_busy", 64'(busy_o), 1);
        check("t5_stalled", 64'(req_valid_o), 1);
        @(posedge clk);
        #1 req_ready_i = 1'b1;
        drain("t5_drain");
        // reset while waiting for completion with two commands queued
        @(posedge clk);
        #1 push(3'd1, 32'h3000, 4'h0, 4'd1);
        @(posedge clk);
        @(posedge clk);
        #1 req_ready_i = 1'b0;
        push(3'd3, 32'h0, 4'h0, 4'd2);
        push(3'd3, 32'h0, 4'h0, 4'd4);
        @(negedge clk);
        check("t6_busy", 64'(busy_o), 1);
        check("t6_waiting", 64'(req_valid_o), 0);
        #2 rst_ni = 1'b0;
        exp_req.delete();
        exp_rsp.delete();
        @(negedge clk);
        check("t6_req_valid", 64'(req_valid_o), 0);
        check("t6_busy_rst", 64'(busy_o), 0);
        check("t6_rsp_valid", 64'(cmo_rsp_valid_o), 0);
        check("t6_req_addr", 64'(req_addr_o), 0);
        check("t6_wdata", req_wdata_o, 0);
        @(posedge clk);
        #1 rst_ni = 1'b1;
        req_ready_i = 1'b1;
        @(negedge clk);
        check("t6_ready", 64'(cmo_ready_o), 1);
        check("t6_idle", 64'(busy_o), 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t6_no_rsp", 64'(cmo_rsp_valid_o), 0);
            check("t6_no_req", 64'(req_valid_o), 0);
        end
        // randomized traffic with a randomly stalling handler
        @(posedge clk);
        #1 rand_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            push(3'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15)), 4'($urandom));
        end
        drain("rand_drain");
        rand_ready = 1'b0;
        @(posedge clk);
        #1 req_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        check("final_req_model", 64'(exp_req.size()), 0);
        check("final_rsp_model", 64'(exp_rsp.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
